// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: pin side of the GPIO register slave. It registers the pad drive and
// direction, synchronises and debounces the pad inputs, and raises sticky edge interrupts.
module gpio_pin_ctrl #(
   parameter int GPIO_WIDTH      = 8,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [GPIO_WIDTH-1:0]     out_data_reg,
   input  logic [GPIO_WIDTH-1:0]     dir_reg,
   input  logic [2*GPIO_WIDTH-1:0]   irq_en_reg,
   input  logic [GPIO_WIDTH-1:0]     irq_clr,
   input  logic                      irq_clr_valid,
   input  logic [GPIO_WIDTH-1:0]     gpio_i,
   output logic [GPIO_WIDTH-1:0]     gpio_o,
   output logic [GPIO_WIDTH-1:0]     gpio_t,
   output logic [GPIO_WIDTH-1:0]     in_data,
   output logic [GPIO_WIDTH-1:0]     irq_status,
   output logic                      irq
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [GPIO_WIDTH-1:0] gpio_o_q;
   logic [GPIO_WIDTH-1:0] gpio_t_q;
   logic [GPIO_WIDTH-1:0] sync1_q;
   logic [GPIO_WIDTH-1:0] sync2_q;
   logic [GPIO_WIDTH-1:0] stb_q;
   logic [GPIO_WIDTH-1:0] stb_d;
   logic [GPIO_WIDTH-1:0] stb_dly_q;
   logic [CW-1:0]         cnt_q [GPIO_WIDTH];
   logic [CW-1:0]         cnt_d [GPIO_WIDTH];
   logic [GPIO_WIDTH-1:0] irq_status_q;
   logic [GPIO_WIDTH-1:0] irq_status_d;
   logic                  irq_q;
   logic [GPIO_WIDTH-1:0] rise_s;
   logic [GPIO_WIDTH-1:0] fall_s;

   // Per-pin debounce: a changed input must differ from the stable value for
   // DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
   always_comb begin
      stb_d = stb_q;
      for (int i = 0; i < GPIO_WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] == stb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stb_d[i] = sync2_q[i];
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   // Edges are only reported on input-direction pins; a simultaneous clear loses to a new edge.
   assign rise_s = stb_q & ~stb_dly_q & ~dir_reg & irq_en_reg[GPIO_WIDTH-1:0];
   assign fall_s = ~stb_q & stb_dly_q & ~dir_reg & irq_en_reg[2*GPIO_WIDTH-1:GPIO_WIDTH];
   assign irq_status_d = (irq_status_q & ~({GPIO_WIDTH{irq_clr_valid}} & irq_clr))
                         | rise_s | fall_s;

   // State registers for the whole pin bank.
   always_ff @(posedge clock) begin
      if (reset) begin
         gpio_o_q     <= '0;
         gpio_t_q     <= '1;
         sync1_q      <= '0;
         sync2_q      <= '0;
         stb_q        <= '0;
         stb_dly_q    <= '0;
         irq_status_q <= '0;
         irq_q        <= 1'b0;
         for (int i = 0; i < GPIO_WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         gpio_o_q     <= out_data_reg;
         gpio_t_q     <= ~dir_reg;
         sync1_q      <= gpio_i;
         sync2_q      <= sync1_q;
         stb_q        <= stb_d;
         stb_dly_q    <= stb_q;
         irq_status_q <= irq_status_d;
         irq_q        <= |irq_status_q;
         for (int i = 0; i < GPIO_WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign gpio_o     = gpio_o_q;
   assign gpio_t     = gpio_t_q;
   assign in_data    = stb_q;
   assign irq_status = irq_status_q;
   assign irq        = irq_q;

endmodule

// File: tb/tb_gpio_pin_ctrl.sv
// Scoreboard bench for gpio_pin_ctrl (W=8, D=4): stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_gpio_pin_ctrl;

   localparam int S_GO  = 0;
   localparam int S_GT  = 1;
   localparam int S_IN  = 2;
   localparam int S_ST  = 3;
   localparam int S_IRQ = 4;

   typedef struct {
      int          cyc;
      int          sig;
      logic [15:0] mask;
      logic [15:0] val;
      string       name;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  out_data_reg;
   logic [7:0]  dir_reg;
   logic [15:0] irq_en_reg;
   logic [7:0]  irq_clr;
   logic        irq_clr_valid;
   logic [7:0]  gpio_i;
   logic [7:0]  gpio_o;
   logic [7:0]  gpio_t;
   logic [7:0]  in_data;
   logic [7:0]  irq_status;
   logic        irq;

   int   cyc    = 0;
   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   exp_t e_m;
   logic [15:0] act_m;

   gpio_pin_ctrl #(.GPIO_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .out_data_reg(out_data_reg), .dir_reg(dir_reg),
      .irq_en_reg(irq_en_reg), .irq_clr(irq_clr), .irq_clr_valid(irq_clr_valid),
      .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .in_data(in_data),
      .irq_status(irq_status), .irq(irq)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this cycle, half a period after the edge.
   always @(negedge clock) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e_m = q.pop_front();
         case (e_m.sig)
            S_GO:    act_m = {8'h00, gpio_o};
            S_GT:    act_m = {8'h00, gpio_t};
            S_IN:    act_m = {8'h00, in_data};
            S_ST:    act_m = {8'h00, irq_status};
            S_IRQ:   act_m = {15'h0000, irq};
            default: act_m = 16'hxxxx;
         endcase
         checks++;
         if (e_m.cyc != cyc) begin
            errors++;
            $display("FAIL %s: check due at cycle %0d reached at cycle %0d", e_m.name, e_m.cyc, cyc);
         end else if ((act_m & e_m.mask) !== (e_m.val & e_m.mask)) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %h expected %h (mask %h)",
                     e_m.name, cyc, act_m & e_m.mask, e_m.val & e_m.mask, e_m.mask);
         end
      end
   end

   task automatic expect_at(input int c, input int sig, input logic [15:0] mask,
                            input logic [15:0] val, input string name);
      exp_t e;
      int   p;
      e.cyc = c; e.sig = sig; e.mask = mask; e.val = val; e.name = name;
      p = q.size();
      while (p > 0 && q[p-1].cyc > c) p--;
      q.insert(p, e);
   endtask

   task automatic expect_range(input int c0, input int c1, input int sig, input logic [15:0] mask,
                               input logic [15:0] val, input string name);
      for (int c = c0; c <= c1; c++) expect_at(c, sig, mask, val, name);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

   initial begin
      reset = 1'b1; gpio_i = 8'hFF; dir_reg = 8'h00; out_data_reg = 8'h00;
      irq_en_reg = 16'h0000; irq_clr = 8'h00; irq_clr_valid = 1'b0;

      // Reset held for 10 edges with all pads high.
      expect_range(1, 10, S_GT, 16'h00FF, 16'h00FF, "rst_gpio_t");
      expect_range(1, 10, S_GO, 16'h00FF, 16'h0000, "rst_gpio_o");
      expect_range(1, 10, S_IRQ, 16'h0001, 16'h0000, "rst_irq");
      expect_range(1, 10, S_IN, 16'h00FF, 16'h0000, "rst_in_data");
      wait_to(10);
      reset = 1'b0;
      expect_at(15, S_IN, 16'h00FF, 16'h0000, "post_rst_in_early");
      expect_at(16, S_IN, 16'h00FF, 16'h00FF, "post_rst_in_data");
      expect_range(17, 18, S_ST, 16'h00FF, 16'h0000, "post_rst_no_en");

      // Output drive, one cycle of latency.
      wait_to(18);
      dir_reg = 8'h0F; out_data_reg = 8'hA5;
      expect_at(18, S_GT, 16'h00FF, 16'h00FF, "drive_t_before");
      expect_at(19, S_GT, 16'h00FF, 16'h00F0, "drive_t");
      expect_at(19, S_GO, 16'h00FF, 16'h00A5, "drive_o");

      wait_to(20);
      dir_reg = 8'h00; gpio_i = 8'h00;
      expect_at(21, S_GT, 16'h00FF, 16'h00FF, "dir_back");
      expect_at(25, S_IN, 16'h00FF, 16'h00FF, "settle_low_early");
      expect_at(26, S_IN, 16'h00FF, 16'h0000, "settle_low");
      expect_range(21, 29, S_ST, 16'h00FF, 16'h0000, "settle_no_status");

      // 3-cycle glitch on pin 0 is rejected even with rising enable set.
      wait_to(30);
      irq_en_reg = 16'h0001; gpio_i = 8'h01;
      expect_range(31, 40, S_IN, 16'h0001, 16'h0000, "reject_in");
      expect_range(31, 40, S_ST, 16'h00FF, 16'h0000, "reject_status");
      wait_to(33);
      gpio_i = 8'h00;

      // 4-cycle pulse is accepted; rising edge raises status and irq.
      wait_to(40);
      gpio_i = 8'h01;
      expect_at(45, S_IN, 16'h0001, 16'h0000, "accept_early");
      expect_at(46, S_IN, 16'h0001, 16'h0001, "accept_in");
      expect_at(46, S_ST, 16'h00FF, 16'h0000, "rise_status_early");
      expect_at(47, S_ST, 16'h00FF, 16'h0001, "rise_status");
      expect_at(47, S_IRQ, 16'h0001, 16'h0000, "rise_irq_early");
      expect_at(48, S_IRQ, 16'h0001, 16'h0001, "rise_irq");
      wait_to(44);
      gpio_i = 8'h00;
      expect_at(49, S_IN, 16'h0001, 16'h0001, "fall_in_early");
      expect_at(50, S_IN, 16'h0001, 16'h0000, "fall_in");
      expect_range(51, 54, S_ST, 16'h00FF, 16'h0001, "fall_not_enabled");

      // Clear strobe coincides with a new rising event: set wins.
      wait_to(55);
      gpio_i = 8'h01;
      wait_to(61);
      irq_clr = 8'h01; irq_clr_valid = 1'b1;
      expect_at(62, S_ST, 16'h00FF, 16'h0001, "collide_status");
      expect_at(63, S_ST, 16'h00FF, 16'h0001, "collide_hold");
      wait_to(62);
      irq_clr_valid = 1'b0;

      // Clear data without the strobe is ignored; a lone strobe then clears.
      wait_to(64);
      expect_range(65, 66, S_ST, 16'h00FF, 16'h0001, "clr_no_valid");
      wait_to(66);
      irq_clr_valid = 1'b1;
      expect_at(67, S_ST, 16'h00FF, 16'h0000, "clr_status");
      expect_at(67, S_IRQ, 16'h0001, 16'h0001, "clr_irq_lag");
      expect_at(68, S_IRQ, 16'h0001, 16'h0000, "clr_irq");
      wait_to(67);
      irq_clr_valid = 1'b0; irq_clr = 8'h00;

      // Output-direction pin 1 looped back: readback follows, no interrupts.
      wait_to(70);
      irq_en_reg = 16'h0202; dir_reg = 8'h02; out_data_reg = 8'h02; gpio_i = 8'h03;
      expect_at(71, S_GT, 16'h00FF, 16'h00FD, "loop_t");
      expect_at(71, S_GO, 16'h00FF, 16'h0002, "loop_o_hi");
      expect_at(75, S_IN, 16'h00FF, 16'h0001, "loop_in_hi_early");
      expect_at(76, S_IN, 16'h00FF, 16'h0003, "loop_in_hi");
      expect_range(71, 79, S_ST, 16'h00FF, 16'h0000, "gate_rise");
      wait_to(80);
      out_data_reg = 8'h00; gpio_i = 8'h01;
      expect_at(81, S_GO, 16'h00FF, 16'h0000, "loop_o_lo");
      expect_at(85, S_IN, 16'h00FF, 16'h0003, "loop_in_lo_early");
      expect_at(86, S_IN, 16'h00FF, 16'h0001, "loop_in_lo");
      expect_range(81, 90, S_ST, 16'h00FF, 16'h0000, "gate_fall");
      expect_at(90, S_IRQ, 16'h0001, 16'h0000, "gate_irq");

      wait_to(92);
      while (q.size() > 0) begin
         e_m = q.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: check due at cycle %0d never reached", e_m.name, e_m.cyc);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gpio_pin_ctrl.md
# gpio_pin_ctrl

Pin-side companion to the GPIO_param AXI4-Lite register slave. It consumes that slave's four 32-bit registers and drives/samples the physical GPIO bank. Its duties are direction control, registered output drive, two-flop input synchronisation, per-pin debounce and edge-detect interrupt generation. Debounced input state and sticky interrupt status are returned to the slave for readback.

## Interface
Parameters:
- `GPIO_WIDTH`, 8: number of pins; legal range 1..16.
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a changed input must persist before being accepted; legal range 1..65535. Counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

Ports:
- `clock` in 1: single clock for the whole block.
- `reset` in 1: synchronous, active-high reset.
- `out_data_reg` in GPIO_WIDTH: value to drive on output pins (slv_reg0).
- `dir_reg` in GPIO_WIDTH: per-pin direction, 1 = output, 0 = input (slv_reg1).
- `irq_en_reg` in 2*GPIO_WIDTH: interrupt enables (slv_reg2).
  - Bits [W-1:0] enable the rising edge.
  - Bits [2W-1:W] enable the falling edge.
- `irq_clr` in GPIO_WIDTH: write-1-to-clear mask for status (slv_reg3 write data).
- `irq_clr_valid` in 1: one-cycle strobe; qualifies `irq_clr`.
- `gpio_i` in GPIO_WIDTH: asynchronous pad inputs.
- `gpio_o` out GPIO_WIDTH: pad output data.
- `gpio_t` out GPIO_WIDTH: pad tristate, 1 = high-Z (input).
- `in_data` out GPIO_WIDTH: debounced pin state for readback.
- `irq_status` out GPIO_WIDTH: sticky per-pin edge status.
- `irq` out 1: level interrupt, OR of `irq_status`.

## Operation
- **Output path:**
  - `gpio_o <= out_data_reg`.
  - `gpio_t <= ~dir_reg`.
  - Both are registered, 1 cycle latency.
- **Input sync:** `sync1 <= gpio_i`, then `sync2 <= sync1`. No logic between the two flops.
- **Debounce, per pin:** the pin has a counter `cnt` and a stable bit `stb`. This is an implicit two-state FSM (STABLE when cnt==0, PENDING otherwise).
  - sync2 == stb: `cnt <= 0`. A glitch shorter than DEBOUNCE_CYCLES is discarded.
  - sync2 != stb and cnt < DEBOUNCE_CYCLES-1: `cnt <= cnt+1`.
  - sync2 != stb and cnt == DEBOUNCE_CYCLES-1: `stb <= sync2`, `cnt <= 0`.
  - `in_data = stb`.
  - Output-direction pins are still sampled, giving readback of the driven value.
- **Edge detect:** `stb_d <= stb`.
  - rise[i] = stb[i] & ~stb_d[i] & ~dir_reg[i] & irq_en_reg[i].
  - fall[i] = ~stb[i] & stb_d[i] & ~dir_reg[i] & irq_en_reg[W+i].
- **Status:** `irq_status[i] <= (irq_status[i] & ~(irq_clr_valid & irq_clr[i])) | rise[i] | fall[i]`.
  - When set and clear hit the same cycle, set wins.
  - `irq_clr` is ignored when `irq_clr_valid` is 0.
- **irq:** `irq <= |irq_status`, registered.
- Changing `irq_en_reg` or `dir_reg` never clears status already set.

## Timing
- **Reset values:**
  - `gpio_o` = 0, `gpio_t` = all ones.
  - `in_data` = 0, `irq_status` = 0, `irq` = 0.
  - sync1, sync2, stb_d and all cnt = 0.
- Reset mid-debounce discards the pending count. The first clean edge after reset deassertion restarts the counting.
- **Output latency:** register change at edge n appears on `gpio_o`/`gpio_t` after edge n+1.
- **Input latency:** a pin change captured into sync1 at edge k propagates as follows:
  - sync2 updates at edge k+1.
  - `in_data` updates at edge k+1+DEBOUNCE_CYCLES.
  - `irq_status` sets at edge k+2+DEBOUNCE_CYCLES.
  - `irq` asserts at edge k+3+DEBOUNCE_CYCLES.
  - Example: DEBOUNCE_CYCLES=4 gives `in_data` at k+5 and `irq` at k+7.
- **Clear latency:** clear strobe at edge n gives `irq_status` bit 0 after edge n, and `irq` low after edge n+1 if no other bits are set.
- **Reset-time edges:** a pin held high through reset produces a rising event DEBOUNCE_CYCLES+1 cycles after reset release. It latches only if the rising enable is already set.
- **No stuck state:** the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap and no stuck state.

## Test plan
- **Reset:** assert `reset` 10 cycles with `gpio_i`=8'hFF. Require `gpio_t`=8'hFF, `gpio_o`=0, `irq`=0 during reset. Require `in_data`=8'hFF exactly 5 cycles after sync1 captures post-reset (D=4).
- **Drive:** set `dir_reg`=8'h0F and `out_data_reg`=8'hA5. Require `gpio_t`=8'hF0 and `gpio_o`=8'hA5 one cycle later.
- **Debounce reject:** pulse `gpio_i[0]` high for 3 cycles (D=4). Require `in_data[0]` to stay 0 and `irq_status` to stay 0. A 4-cycle pulse must set `in_data[0]`.
- **Rising irq:** set `irq_en_reg`=16'h0001 and `dir_reg`=0, then raise `gpio_i[0]` at edge k. Require `irq_status`=8'h01 at k+6 and `irq`=1 at k+7. A falling edge alone must leave bit 0 unchanged.
- **Clear vs set collision:** time a `irq_clr_valid` with `irq_clr`=8'h01 to coincide with a new rising event on pin 0. Require `irq_status[0]` to stay 1. A later lone clear gives 0, with `irq` low one cycle after.
- **Direction gating:** set `dir_reg[1]`=1 with both enables set, then toggle `out_data_reg[1]` looped back to `gpio_i[1]`. Require `in_data[1]` to follow and `irq_status[1]` to stay 0.
